io_port_ctrl: RTL and testbench



---
 rtl/io_port_pkg.sv | 13 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/io_port_ctrl.sv | 148 ++++++++++++++
 tb/tb_io_port_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared types and defaults for the external I/O port controller.
// Contents: RX interrupt FSM state type and the default acknowledge code.
package io_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK
    } rx_state_t;

    localparam logic [7:0] DEFAULT_ACK_CODE = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   push, push_data      write request/data (ignored while full)
//   pop                  read request (ignored while empty)
//   pop_data             current head entry (valid while !empty)
//   full, empty          status decoded from the registered count
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the pre-edge count, so a push while full is refused
    // even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/io_port_ctrl.sv
// External I/O port controller on the CPU's I_Port/int_sig/O_Port pins.
// Host bytes are buffered in an RX FIFO and presented one at a time on I_Port
// with an int_sig pulse, retried on timeout until the CPU writes ACK_CODE.
// Other CPU output writes are buffered in a TX FIFO drained by the host.
// Ports:
//   clk, rstn                        clock, synchronous active-low reset
//   host_data, host_valid/ready      host -> RX stream
//   I_Port, int_sig                  registered byte + interrupt to the CPU
//   O_Port, out_wr                   CPU output port write
//   out_data, out_valid/ready        TX -> host stream (FWFT head)
//   tx_ovf                           sticky: CPU write dropped on full TX
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  ACK_CODE  = DEFAULT_ACK_CODE,
    parameter int unsigned INT_PULSE = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [7:0] I_Port,
    output logic       int_sig,
    input  logic [7:0] O_Port,
    input  logic       out_wr,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       tx_ovf
);

    localparam int unsigned PW = (INT_PULSE > 1) ? $clog2(INT_PULSE) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    rx_state_t    state, state_nxt;
    logic [PW-1:0] pulse_cnt, pulse_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [7:0]   i_port_nxt;
    logic         int_nxt;

    logic       ack;
    logic       rx_pop;
    logic       rx_full, rx_empty;
    logic [7:0] rx_head;
    logic       tx_push;
    logic       tx_full, tx_empty;

    assign ack     = out_wr && (O_Port == ACK_CODE);
    // Acks are never forwarded to TX, whatever the FSM state.
    assign tx_push = out_wr && !ack;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (host_valid),
        .push_data (host_data),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (O_Port),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    assign host_ready = !rx_full;
    assign out_valid  = !tx_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            I_Port    <= '0;
            int_sig   <= 1'b0;
            pulse_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            I_Port    <= i_port_nxt;
            int_sig   <= int_nxt;
            pulse_cnt <= pulse_nxt;
            tmo_cnt   <= tmo_nxt;
        end
    end

    // pulse_cnt counts down from INT_PULSE-1 so int_sig is high for exactly
    // INT_PULSE cycles; tmo_cnt reaching TIMEOUT-1 re-raises the request.
    always_comb begin
        state_nxt  = state;
        i_port_nxt = I_Port;
        int_nxt    = int_sig;
        pulse_nxt  = pulse_cnt;
        tmo_nxt    = tmo_cnt;
        rx_pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_empty) begin
                    i_port_nxt = rx_head;
                    int_nxt    = 1'b1;
                    pulse_nxt  = PW'(INT_PULSE - 1);
                    state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    rx_pop    = 1'b1;
                    int_nxt   = 1'b0;
                    state_nxt = ST_IDLE;
                end else if (pulse_cnt == '0) begin
                    int_nxt   = 1'b0;
                    tmo_nxt   = '0;
                    state_nxt = ST_WAIT_ACK;
                end else begin
                    pulse_nxt = pulse_cnt - 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (ack) begin
                    rx_pop    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    int_nxt   = 1'b1;
                    pulse_nxt = PW'(INT_PULSE - 1);
                    state_nxt = ST_REQ;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn)                  tx_ovf <= 1'b0;
        else if (tx_push && tx_full) tx_ovf <= 1'b1;
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_io_port_ctrl;

    localparam int DEPTH     = 4;
    localparam int INT_PULSE = 2;
    localparam int TIMEOUT   = 64;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] I_Port;
    logic       int_sig;
    logic [7:0] O_Port;
    logic       out_wr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       tx_ovf;

    io_port_ctrl #(
        .DEPTH     (DEPTH),
        .ACK_CODE  (8'hFF),
        .INT_PULSE (INT_PULSE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .I_Port     (I_Port),
        .int_sig    (int_sig),
        .O_Port     (O_Port),
        .out_wr     (out_wr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tx_ovf     (tx_ovf)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    // Reference model: byte queues plus "cycles since last interrupt rise".
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          m_busy;
    int unsigned m_t;
    logic [7:0]  m_iport;
    bit          m_int;
    bit          m_ovf;

    int unsigned rise_q[$];
    logic        prev_int;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit ack, rx_acc, tx_pop, tx_acc, tx_req;
        if (!rstn) begin
            rxq.delete();
            txq.delete();
            m_busy  = 0;
            m_t     = 0;
            m_iport = '0;
            m_int   = 0;
            m_ovf   = 0;
            return;
        end
        ack    = out_wr && (O_Port == 8'hFF);
        tx_req = out_wr && !ack;
        rx_acc = host_valid && (rxq.size() < DEPTH);
        tx_pop = out_ready && (txq.size() > 0);
        tx_acc = tx_req && (txq.size() < DEPTH);
        if (tx_req && !tx_acc) m_ovf = 1;
        if (m_busy) begin
            if (ack) begin
                void'(rxq.pop_front());
                m_busy = 0;
                m_int  = 0;
            end else begin
                m_t++;
                if (m_t == INT_PULSE + TIMEOUT) m_t = 0;
                m_int = (m_t < INT_PULSE);
            end
        end else if (rxq.size() > 0) begin
            m_iport = rxq[0];
            m_busy  = 1;
            m_t     = 0;
            m_int   = 1;
        end
        if (rx_acc) rxq.push_back(host_data);
        if (tx_pop) void'(txq.pop_front());
        if (tx_acc) txq.push_back(O_Port);
    endtask

    task automatic check_all();
        check_eq("i_port",     32'(I_Port),     32'(m_iport));
        check_eq("int_sig",    32'(int_sig),    32'(m_int));
        check_eq("host_ready", 32'(host_ready), 32'(rxq.size() < DEPTH));
        check_eq("out_valid",  32'(out_valid),  32'(txq.size() > 0));
        if (txq.size() > 0) check_eq("out_data", 32'(out_data), 32'(txq[0]));
        check_eq("tx_ovf",     32'(tx_ovf),     32'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        if (int_sig === 1'b1 && prev_int !== 1'b1) rise_q.push_back(cyc);
        prev_int = int_sig;
        check_all();
    endtask

    task automatic idle_inputs();
        host_valid = 1'b0;
        host_data  = '0;
        out_wr     = 1'b0;
        O_Port     = '0;
        out_ready  = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        host_valid = 1'b1;
        host_data  = b;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] b);
        out_wr = 1'b1;
        O_Port = b;
        tick();
        out_wr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_tx [4];
        prev_int = 1'b0;
        rstn = 1'b0;
        idle_inputs();
        repeat (2) tick();
        check_eq("rst_int",        32'(int_sig),    32'd0);
        check_eq("rst_iport",      32'(I_Port),     32'd0);
        check_eq("rst_host_ready", 32'(host_ready), 32'd1);
        check_eq("rst_out_valid",  32'(out_valid),  32'd0);
        check_eq("rst_tx_ovf",     32'(tx_ovf),     32'd0);
        rstn = 1'b1;
        tick();

        // First presentation, pulse width, then timeout retry.
        rise_q.delete();
        push_byte(8'h3C);
        tick();
        check_eq("first_iport", 32'(I_Port),  32'h3C);
        check_eq("first_int",   32'(int_sig), 32'd1);
        tick();
        check_eq("pulse_hi2",   32'(int_sig), 32'd1);
        tick();
        check_eq("pulse_lo",    32'(int_sig), 32'd0);
        for (int i = 0; i < 100 && rise_q.size() < 2; i++) tick();
        check_eq("retry_seen", 32'(rise_q.size()), 32'd2);
        if (rise_q.size() >= 2)
            check_eq("retry_gap", 32'(rise_q[1] - rise_q[0]), 32'(INT_PULSE + TIMEOUT));
        check_eq("retry_iport", 32'(I_Port), 32'h3C);
        cpu_write(8'hFF);
        check_eq("ack_req_int", 32'(int_sig), 32'd0);
        repeat (2) tick();

        // Ack in WAIT_ACK, next queued byte presented one cycle later.
        push_byte(8'h3C);
        push_byte(8'h5A);
        repeat (5) tick();
        cpu_write(8'hFF);
        tick();
        check_eq("next_iport", 32'(I_Port),  32'h5A);
        check_eq("next_int",   32'(int_sig), 32'd1);
        cpu_write(8'hFF);
        repeat (2) tick();

        // Fill RX with no acks; a fifth push is refused.
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        check_eq("rx_full_ready", 32'(host_ready), 32'd0);
        push_byte(8'hA4);
        check_eq("rx_5th_refused", 32'(host_ready), 32'd0);

        // TX overflow and in-order drain.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_write(8'h11 + 8'(i));
        check_eq("tx_ovf_set", 32'(tx_ovf), 32'd1);
        for (int i = 0; i < 4; i++) exp_tx[i] = 8'h11 + 8'(i);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", 32'(out_valid), 32'd1);
            check_eq("drain_data",  32'(out_data),  32'(exp_tx[i]));
            tick();
        end
        out_ready = 1'b0;
        check_eq("drain_empty",  32'(out_valid), 32'd0);
        check_eq("tx_ovf_stick", 32'(tx_ovf),    32'd1);

        // Reset during REQ with bytes queued.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        push_byte(8'h21);
        push_byte(8'h22);
        push_byte(8'h23);
        check_eq("pre_rst_int", 32'(int_sig), 32'd1);
        rstn = 1'b0;
        tick();
        check_eq("midrst_int",        32'(int_sig),    32'd0);
        check_eq("midrst_iport",      32'(I_Port),     32'd0);
        check_eq("midrst_host_ready", 32'(host_ready), 32'd1);
        check_eq("midrst_out_valid",  32'(out_valid),  32'd0);
        check_eq("midrst_tx_ovf",     32'(tx_ovf),     32'd0);
        rstn = 1'b1;
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            host_valid = 1'($urandom_range(0, 1));
            host_data  = 8'($urandom);
            out_wr     = ($urandom_range(0, 3) == 0);
            O_Port     = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            rstn       = ($urandom_range(0, 599) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
